// File: rtl/seq_detect_scheduler_pkg.sv
// Shared types for the multi-slot serial sequence detector: FSM states,
// default widths and the slot-table entry layout.
package seq_detect_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    typedef struct packed {
        logic [PAT_W_DEF-1:0] pattern;
        logic [LEN_W_DEF-1:0] len;
        logic                 en;
    } slot_t;

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Configuration, serial-bit handshake and match-report bundle of the
// sequence detect scheduler.
interface seq_detect_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int PAT_W     = 8,
    parameter int LEN_W     = 4
);
    logic                         cfg_we;
    logic [$clog2(NUM_SLOTS)-1:0] cfg_slot;
    logic [PAT_W-1:0]             cfg_pattern;
    logic [LEN_W-1:0]             cfg_len;
    logic                         cfg_en;
    logic                         cfg_clr;
    logic                         bit_valid;
    logic                         bit_in;
    logic                         bit_ready;
    logic                         match_valid;
    logic [NUM_SLOTS-1:0]         match_vec;
    logic                         match_any;
    logic [7:0]                   match_cnt;

    modport master (
        output cfg_we, cfg_slot, cfg_pattern, cfg_len, cfg_en, cfg_clr,
        output bit_valid, bit_in,
        input  bit_ready, match_valid, match_vec, match_any, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_slot, cfg_pattern, cfg_len, cfg_en, cfg_clr,
        input  bit_valid, bit_in,
        output bit_ready, match_valid, match_vec, match_any, match_cnt
    );
endinterface

// File: rtl/seq_match_cmp.sv
// Combinational masked comparator: compares the newest len history bits
// against one slot pattern, guarded by enable, length range and fill level.
module seq_match_cmp #(
    parameter int PAT_W  = 8,
    parameter int LEN_W  = 4,
    parameter int FILL_W = 4
) (
    input  logic [PAT_W-1:0]  hist,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [LEN_W-1:0]  len,
    input  logic [FILL_W-1:0] fill,
    input  logic              en,
    output logic              hit
);
    logic [PAT_W-1:0] mask;
    logic             len_ok;

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        // A zero or oversized length never matches; too few bits seen yet never matches.
        len_ok = (len != '0) && (int'(len) <= PAT_W) && (int'(fill) >= int'(len));
        hit    = en && len_ok && (((hist ^ pattern) & mask) == '0);
    end
endmodule

// File: rtl/seq_detect_scheduler.sv
// Time-shares one masked comparator over NUM_SLOTS pattern slots: each accepted
// bit triggers a fixed NUM_SLOTS-cycle scan, then a one-cycle match report.
module seq_detect_scheduler
    import seq_detect_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int PAT_W     = PAT_W_DEF,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detect_scheduler_if.slave bus
);
    localparam int                IDX_W    = $clog2(NUM_SLOTS);
    localparam int                FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_SLOTS - 1);

    state_t               state_q, state_d;
    logic [PAT_W-1:0]     hist_q, hist_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_SLOTS-1:0] scratch_q, scratch_d;
    logic                 match_valid_q, match_valid_d;
    logic [NUM_SLOTS-1:0] match_vec_q, match_vec_d;
    logic                 match_any_q, match_any_d;
    logic [7:0]           match_cnt_q, match_cnt_d;
    slot_t                slot_tbl_q [NUM_SLOTS];
    slot_t                slot_tbl_d [NUM_SLOTS];

    slot_t cur_slot;
    logic  hit;

    // The comparator always sees the registered entry, so a same-cycle write lands on later scans.
    assign cur_slot = slot_tbl_q[idx_q];

    seq_match_cmp #(
        .PAT_W  (PAT_W),
        .LEN_W  (LEN_W),
        .FILL_W (FILL_W)
    ) u_cmp (
        .hist    (hist_q),
        .pattern (cur_slot.pattern),
        .len     (cur_slot.len),
        .fill    (fill_q),
        .en      (cur_slot.en),
        .hit     (hit)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through this block infers a latch.
        state_d       = state_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        idx_d         = idx_q;
        scratch_d     = scratch_q;
        match_valid_d = 1'b0;
        match_vec_d   = match_vec_q;
        match_any_d   = match_any_q;
        match_cnt_d   = match_cnt_q;
        slot_tbl_d    = slot_tbl_q;

        if (bus.cfg_we) begin
            slot_tbl_d[bus.cfg_slot] = '{pattern: bus.cfg_pattern, len: bus.cfg_len, en: bus.cfg_en};
        end

        case (state_q)
            IDLE: begin
                if (bus.bit_valid) begin
                    hist_d    = {hist_q[PAT_W-2:0], bus.bit_in};
                    fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
                    idx_d     = '0;
                    scratch_d = '0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                scratch_d[idx_q] = hit;
                if (idx_q == IDX_LAST) begin
                    match_vec_d   = scratch_d;
                    match_any_d   = |scratch_d;
                    match_valid_d = 1'b1;
                    if ((|scratch_d) && (match_cnt_q != 8'hFF)) begin
                        match_cnt_d = match_cnt_q + 8'd1;
                    end
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over acceptance and scan; the last reported result survives it.
        if (bus.cfg_clr) begin
            hist_d        = '0;
            fill_d        = '0;
            idx_d         = '0;
            scratch_d     = '0;
            state_d       = IDLE;
            match_valid_d = 1'b0;
            match_vec_d   = match_vec_q;
            match_any_d   = match_any_q;
            match_cnt_d   = match_cnt_q;
        end
    end

    // NOTE: the slot table is reset too, so every slot starts disabled rather than holding X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hist_q        <= '0;
            fill_q        <= '0;
            idx_q         <= '0;
            scratch_q     <= '0;
            match_valid_q <= 1'b0;
            match_vec_q   <= '0;
            match_any_q   <= 1'b0;
            match_cnt_q   <= '0;
            slot_tbl_q    <= '{default: '0};
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            state_q       <= state_d;
            hist_q        <= hist_d;
            fill_q        <= fill_d;
            idx_q         <= idx_d;
            scratch_q     <= scratch_d;
            match_valid_q <= match_valid_d;
            match_vec_q   <= match_vec_d;
            match_any_q   <= match_any_d;
            match_cnt_q   <= match_cnt_d;
            slot_tbl_q    <= slot_tbl_d;
        end
    end

    assign bus.bit_ready   = (state_q == IDLE);
    assign bus.match_valid = match_valid_q;
    assign bus.match_vec   = match_vec_q;
    assign bus.match_any   = match_any_q;
    assign bus.match_cnt   = match_cnt_q;
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Scoreboard bench for seq_detect_scheduler: a reference model predicts each
// match report at bit acceptance; a negedge monitor compares the reports.
module tb_seq_detect_scheduler;
    localparam int NS = 4;

    typedef struct {
        logic [NS-1:0] vec;
        logic          any;
        logic [7:0]    cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_detect_scheduler_if #(.NUM_SLOTS(NS), .PAT_W(8), .LEN_W(4)) bus ();

    seq_detect_scheduler #(.NUM_SLOTS(NS), .PAT_W(8), .LEN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    m_pat [NS];
    logic [3:0]    m_len [NS];
    logic          m_en  [NS];
    logic [7:0]    m_hist;
    int            m_fill;
    logic [7:0]    m_cnt;
    logic [NS-1:0] held_vec;
    logic [7:0]    held_cnt;
    logic          prev_mv = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_pat[s] = '0;
            m_len[s] = '0;
            m_en[s]  = 1'b0;
        end
        m_hist   = '0;
        m_fill   = 0;
        m_cnt    = '0;
        held_vec = '0;
        held_cnt = '0;
        sb.delete();
    endtask

    task automatic model_accept(input logic b);
        exp_t e;
        m_hist = {m_hist[6:0], b};
        if (m_fill < 8) m_fill++;
        e.vec = '0;
        for (int s = 0; s < NS; s++) begin
            logic ok;
            ok = m_en[s] && (int'(m_len[s]) >= 1) && (int'(m_len[s]) <= 8) && (m_fill >= int'(m_len[s]));
            for (int i = 0; i < 8; i++) begin
                if ((i < int'(m_len[s])) && (m_hist[i] != m_pat[s][i])) ok = 1'b0;
            end
            e.vec[s] = ok;
        end
        e.any = |e.vec;
        if (e.any && (m_cnt != 8'hFF)) m_cnt++;
        e.cnt = m_cnt;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_mv = 1'b0;
        end else begin
            if (bus.match_valid) begin
                check("mv_pulse", prev_mv, 0);
                if (sb.size() == 0) begin
                    check("unexp_mv", bus.match_valid, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("vec", bus.match_vec, e.vec);
                    check("any", bus.match_any, e.any);
                    check("cnt", bus.match_cnt, e.cnt);
                    held_vec = e.vec;
                    held_cnt = e.cnt;
                end
            end
            prev_mv = bus.match_valid;
        end
    end

    task automatic write_slot(input int s, input logic [7:0] pat, input logic [3:0] len, input logic en);
        bus.cfg_we      = 1'b1;
        bus.cfg_slot    = 2'(s);
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_en      = en;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        m_pat[s] = pat;
        m_len[s] = len;
        m_en[s]  = en;
    endtask

    task automatic do_clr();
        bus.cfg_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.cfg_clr = 1'b0;
        m_hist = '0;
        m_fill = 0;
    endtask

    task automatic send_bit(input logic b);
        int cyc = 0;
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        @(negedge clk);
        while (!bus.bit_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.bit_ready) check("ready_timeout", bus.bit_ready, 1);
        model_accept(b);
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_and_wait(input logic b);
        send_bit(b);
        wait_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_we      = 1'b0;
        bus.cfg_slot    = '0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_en      = 1'b0;
        bus.cfg_clr     = 1'b0;
        bus.bit_valid   = 1'b0;
        bus.bit_in      = 1'b0;
        model_reset();
        #22 rst = 1'b0;

        @(negedge clk);
        check("rst_ready", bus.bit_ready, 1);
        check("rst_mv", bus.match_valid, 0);
        check("rst_vec", bus.match_vec, 0);
        check("rst_any", bus.match_any, 0);
        check("rst_cnt", bus.match_cnt, 0);
        @(posedge clk);
        #1;

        // Single 3-bit pattern, then a non-matching tail.
        write_slot(0, 8'b0000_0101, 4'd3, 1'b1);
        send_and_wait(1'b1);
        send_and_wait(1'b0);
        send_and_wait(1'b1);
        check("t1_vec", bus.match_vec, 4'b0001);
        check("t1_cnt", bus.match_cnt, 1);
        send_and_wait(1'b1);
        send_and_wait(1'b1);
        send_and_wait(1'b0);
        check("t2_vec", bus.match_vec, 4'b0000);

        // Two overlapping patterns hit on the same bit.
        write_slot(1, 8'b0000_1101, 4'd4, 1'b1);
        send_and_wait(1'b1);
        send_and_wait(1'b1);
        send_and_wait(1'b0);
        send_and_wait(1'b1);
        check("t3_vec", bus.match_vec, 4'b0011);

        // Fill guard: four zeros needed after a clear.
        do_clr();
        write_slot(2, 8'h00, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send_and_wait(1'b0);
            check("fill_guard_vec", bus.match_vec, 4'b0000);
        end
        send_and_wait(1'b0);
        check("fill_done_vec", bus.match_vec, 4'b0100);

        // Illegal lengths and a disabled slot never match.
        do_clr();
        write_slot(0, 8'hFF, 4'd0, 1'b1);
        write_slot(1, 8'hFF, 4'd9, 1'b1);
        write_slot(2, 8'hFF, 4'd8, 1'b1);
        write_slot(3, 8'hFF, 4'd8, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_and_wait(1'b1);
            if (i == 6) check("len_guard7_vec", bus.match_vec, 4'b0000);
        end
        check("len_guard8_vec", bus.match_vec, 4'b0100);

        // Back-to-back offers: one acceptance every NS+1 cycles.
        begin
            int last_acc = -100;
            int n_acc = 0;
            bus.bit_in    = 1'($urandom_range(0, 1));
            bus.bit_valid = 1'b1;
            for (int i = 0; i < 22; i++) begin
                @(negedge clk);
                if (bus.match_valid) check("mv_latency", i - last_acc, NS + 1);
                if (bus.bit_ready) begin
                    if (n_acc > 0) check("acc_interval", i - last_acc, NS + 1);
                    model_accept(bus.bit_in);
                    last_acc = i;
                    n_acc++;
                end else begin
                    bus.bit_in = 1'($urandom_range(0, 1));
                end
            end
            bus.bit_valid = 1'b0;
            check("acc_count", n_acc, 5);
            wait_drain();
        end

        // Clear during a scan aborts the report and keeps the last result.
        begin
            logic [NS-1:0] keep_vec;
            logic [7:0]    keep_cnt;
            keep_vec      = held_vec;
            keep_cnt      = held_cnt;
            bus.bit_valid = 1'b1;
            bus.bit_in    = 1'b1;
            @(posedge clk);
            #1;
            bus.bit_valid = 1'b0;
            @(posedge clk);
            #1;
            bus.cfg_clr = 1'b1;
            @(posedge clk);
            #1;
            bus.cfg_clr = 1'b0;
            m_hist = '0;
            m_fill = 0;
            @(negedge clk);
            check("clr_ready", bus.bit_ready, 1);
            repeat (8) @(negedge clk);
            check("clr_keep_vec", bus.match_vec, keep_vec);
            check("clr_keep_cnt", bus.match_cnt, keep_cnt);
            @(posedge clk);
            #1;
        end

        // Reset mid-scan returns every output to its reset value.
        bus.bit_valid = 1'b1;
        bus.bit_in    = 1'b1;
        @(posedge clk);
        #1;
        bus.bit_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mrst_ready", bus.bit_ready, 1);
        check("mrst_mv", bus.match_valid, 0);
        check("mrst_vec", bus.match_vec, 0);
        check("mrst_any", bus.match_any, 0);
        check("mrst_cnt", bus.match_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Counter saturation after 256 matching bits.
        write_slot(0, 8'h01, 4'd1, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send_and_wait(1'b1);
        end
        check("sat_cnt", bus.match_cnt, 8'hFF);
        check("sat_vec", bus.match_vec, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
